// File: rtl/shift_left_mc_if.sv
// Handshake and data bundle for the multicycle left shifter.
// The master issues operations; the slave (the shifter) returns results.
interface shift_left_mc_if;
    logic        ctrl_shift;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        data_overflow;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output ctrl_shift, data_operandA, ctrl_shiftamt,
        input  data_result, data_overflow, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_shift, data_operandA, ctrl_shiftamt,
        output data_result, data_overflow, data_resultRDY, busy
    );
endinterface

// File: rtl/shift_left_mc.sv
// Multicycle 32-bit logical left shifter: one conditional stage (16,8,4,2,1) per cycle,
// followed by a one-cycle ready strobe, with overflow flagging any 1 shifted past bit 31.
module shift_left_mc (
    input logic           clock,
    input logic           reset,
    shift_left_mc_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [31:0] value_q, value_d;
    logic [4:0]  amt_q, amt_d;
    logic        ovf_q, ovf_d;
    logic        rdy_q, rdy_d;
    logic        busy_q, busy_d;

    logic [5:0]  step;
    logic [31:0] out_mask;

    // Stage width is 2^k; out_mask selects the top 2^k bits that this stage pushes out.
    always_comb begin
        step     = 6'd1 << k_q;
        out_mask = ~(32'hFFFF_FFFF >> step);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        value_d = value_q;
        amt_d   = amt_q;
        ovf_d   = ovf_q;
        rdy_d   = 1'b0;
        busy_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.ctrl_shift) begin
                    value_d = bus.data_operandA;
                    amt_d   = bus.ctrl_shiftamt;
                    ovf_d   = 1'b0;
                    k_d     = 3'd4;
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (amt_q[k_q]) begin
                    value_d = value_q << step;
                    ovf_d   = ovf_q | (|(value_q & out_mask));
                end
                if (k_q == 3'd0) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                end else begin
                    k_d    = k_q - 3'd1;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= 3'd4;
            value_q <= '0;
            amt_q   <= '0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            value_q <= value_d;
            amt_q   <= amt_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.data_result    = value_q;
    assign bus.data_overflow  = ovf_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_shift_left_mc.sv
// Directed bench for shift_left_mc: a timeline model of accepted operations checked every cycle,
// plus hand-computed literal expectations for each directed case.
module tb_shift_left_mc;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    shift_left_mc_if bus ();

    shift_left_mc dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: age = edges since the accepted start (-1 when no operation is pending or shown).
    // Age 0..4 is busy, age 5 is the ready cycle; results come from plain 64-bit arithmetic.
    int          age;
    logic [31:0] pend_res, held_res;
    logic        pend_ovf, held_ovf;

    always @(posedge clock or negedge reset) begin
        logic [63:0] wide;
        if (!reset) begin
            age      = -1;
            held_res = '0;
            held_ovf = 1'b0;
        end else if (age >= 0 && age < 5) begin
            age = age + 1;
        end else if (bus.ctrl_shift) begin
            wide     = {32'd0, bus.data_operandA} << bus.ctrl_shiftamt;
            pend_res = wide[31:0];
            pend_ovf = |wide[63:32];
            age      = 0;
        end else if (age == 5) begin
            held_res = pend_res;
            held_ovf = pend_ovf;
            age      = -1;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("model_busy", {31'd0, bus.busy}, {31'd0, (age >= 0 && age < 5)});
            chk("model_rdy", {31'd0, bus.data_resultRDY}, {31'd0, (age == 5)});
            if (age == 5) begin
                chk("model_result", bus.data_result, pend_res);
                chk("model_ovf", {31'd0, bus.data_overflow}, {31'd0, pend_ovf});
            end else if (age == -1) begin
                chk("model_hold_result", bus.data_result, held_res);
                chk("model_hold_ovf", {31'd0, bus.data_overflow}, {31'd0, held_ovf});
            end
        end
    end

    // Caller is at a negedge; the start is sampled on the following posedge.
    task automatic start_op(input logic [31:0] a, input logic [4:0] amt);
        bus.data_operandA = a;
        bus.ctrl_shiftamt = amt;
        bus.ctrl_shift    = 1'b1;
    endtask

    // Returns at the negedge inside the ready cycle (or after a bounded wait).
    task automatic wait_ready(input string name, input logic [31:0] exp_res, input logic exp_ovf,
                              input bit inject);
        int cnt;
        int busy_cnt;
        cnt      = 1;
        busy_cnt = 0;
        @(negedge clock);
        bus.ctrl_shift = 1'b0;
        while (!bus.data_resultRDY && cnt < 20) begin
            if (bus.busy) busy_cnt++;
            if (inject && cnt == 2) start_op(32'hFFFF_FFFF, 5'd1);
            @(negedge clock);
            bus.ctrl_shift = 1'b0;
            cnt++;
        end
        chk({name, "_latency"}, cnt, 6);
        chk({name, "_busy_cycles"}, busy_cnt, 5);
        chk({name, "_result"}, bus.data_result, exp_res);
        chk({name, "_ovf"}, {31'd0, bus.data_overflow}, {31'd0, exp_ovf});
    endtask

    task automatic expect_no_ready(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY) seen++;
        end
        chk({name, "_extra_rdy"}, seen, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus.ctrl_shift    = 1'b0;
        bus.data_operandA = '0;
        bus.ctrl_shiftamt = '0;
        repeat (3) @(negedge clock);
        chk("reset_result", bus.data_result, 32'h0);
        chk("reset_ovf", {31'd0, bus.data_overflow}, 32'h0);
        chk("reset_rdy", {31'd0, bus.data_resultRDY}, 32'h0);
        chk("reset_busy", {31'd0, bus.busy}, 32'h0);
        reset = 1'b1;
        @(negedge clock);

        start_op(32'h0000_0001, 5'd31);
        wait_ready("one_by_31", 32'h8000_0000, 1'b0, 1'b0);
        @(negedge clock);
        start_op(32'hFFFF_FFFF, 5'd4);
        wait_ready("ones_by_4", 32'hFFFF_FFF0, 1'b1, 1'b0);
        @(negedge clock);
        start_op(32'h0000_FFFF, 5'd16);
        wait_ready("low_half_by_16", 32'hFFFF_0000, 1'b0, 1'b0);
        @(negedge clock);
        start_op(32'h1234_5678, 5'd0);
        wait_ready("by_0", 32'h1234_5678, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        chk("idle_hold_result", bus.data_result, 32'h1234_5678);
        start_op(32'h8000_0000, 5'd1);
        wait_ready("msb_by_1", 32'h0000_0000, 1'b1, 1'b0);
        @(negedge clock);

        start_op(32'h0000_0003, 5'd5);
        wait_ready("ignore_busy_start", 32'h0000_0060, 1'b0, 1'b1);
        expect_no_ready("ignore_busy_start", 10);

        // Back-to-back: the new start is presented during the ready cycle.
        start_op(32'h0000_00F0, 5'd2);
        wait_ready("b2b_first", 32'h0000_03C0, 1'b0, 1'b0);
        start_op(32'h0000_0001, 5'd3);
        wait_ready("b2b_second", 32'h0000_0008, 1'b0, 1'b0);
        @(negedge clock);

        // Abort mid-flight: after three edges the stage counter sits at k=2.
        start_op(32'hAAAA_AAAA, 5'd7);
        @(negedge clock);
        bus.ctrl_shift = 1'b0;
        repeat (2) @(negedge clock);
        chk("pre_abort_busy", {31'd0, bus.busy}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("abort_result", bus.data_result, 32'h0);
        chk("abort_ovf", {31'd0, bus.data_overflow}, 32'h0);
        chk("abort_busy", {31'd0, bus.busy}, 32'h0);
        chk("abort_rdy", {31'd0, bus.data_resultRDY}, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        expect_no_ready("after_abort", 8);
        start_op(32'h0000_0001, 5'd2);
        wait_ready("post_reset", 32'h0000_0004, 1'b0, 1'b0);
        repeat (3) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
